// File: rtl/rest4b_serial_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and counter sizing helper.
package rest4b_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rest_state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rest4b_serial_rest1b.sv
// 1-bit full subtractor slice.
// D = A - B - Bi_in, Bout is the borrow out.
module rest1b (
  input  logic A,
  input  logic B,
  input  logic Bi_in,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bi_in;
  assign Bout = (~A & B) | (~(A ^ B) & Bi_in);

endmodule

// File: rtl/rest4b_serial.sv
// Bit-serial subtractor, LSB first.
// One borrow FF, start/busy/done handshake.
module rest4b_serial
  import rest4b_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Ai,
  input  logic [WIDTH-1:0] Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Di,
  output logic             Bo
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rest_state_t      state;
  rest_state_t      state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nx;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d_bit;
  logic             br_nx;
  logic             last;

  rest1b u_bit (
    .A     (a_sr[0]),
    .B     (b_sr[0]),
    .Bi_in (br),
    .D     (d_bit),
    .Bout  (br_nx)
  );

  assign last = (cnt == CNT_LAST);
  assign r_nx = {d_bit, r_sr[WIDTH-1:1]};
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (last)  state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Operand/result shifting, borrow, counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Di   <= '0;
      Bo   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr <= Ai;
            b_sr <= Bi;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nx;
          br   <= br_nx;
          cnt  <= cnt + 1'b1;
          if (last) begin
            Di <= r_nx;
            Bo <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rest4b_serial.sv
// Directed bench for the bit-serial subtractor.
// Checks handshake timing, results and corner cases.
module tb_rest4b_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] Ai;
  logic [3:0] Bi;
  logic       busy;
  logic       done;
  logic [3:0] Di;
  logic       Bo;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_di;
  logic       exp_bo;

  rest4b_serial #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Ai    (Ai),
    .Bi    (Bi),
    .busy  (busy),
    .done  (done),
    .Di    (Di),
    .Bo    (Bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input bit full);
    Ai = a;
    Bi = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    Ai = ~a;
    Bi = ~b;
    for (int i = 0; i < 4; i++) begin
      if (full) begin
        chk("busy_run", 32'(busy), 32'd1);
        chk("done_run", 32'(done), 32'd0);
        chk("di_hold", 32'(Di), 32'(exp_di));
      end
      tick();
    end
    exp_di = a - b;
    exp_bo = (a < b);
    chk("done_pulse", 32'(done), 32'd1);
    chk("di", 32'(Di), 32'(exp_di));
    chk("bo", 32'(Bo), 32'(exp_bo));
    if (full) chk("busy_done", 32'(busy), 32'd0);
    tick();
    if (full) chk("done_after", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    Ai = '0;
    Bi = '0;
    exp_di = '0;
    exp_bo = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_di", 32'(Di), 32'd0);
    chk("rst_bo", 32'(Bo), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // basic vectors
    run_op(4'd7, 4'd3, 1'b1);
    run_op(4'd3, 4'd7, 1'b1);
    run_op(4'd0, 4'd1, 1'b1);
    run_op(4'd15, 4'd15, 1'b1);

    // start ignored during SHIFT and DONE
    Ai = 4'd9;
    Bi = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    Ai = 4'd1;
    Bi = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_di", 32'(Di), 32'd7);
    chk("ign_bo", 32'(Bo), 32'd0);
    start = 1'b1;
    tick();
    chk("ign_done_off", 32'(done), 32'd0);
    chk("ign_busy_off", 32'(busy), 32'd0);
    chk("ign_di_hold", 32'(Di), 32'd7);
    start = 1'b0;
    tick();
    chk("ign_not_queued", 32'(busy), 32'd0);
    exp_di = 4'd7;
    exp_bo = 1'b0;

    // reset mid-operation
    Ai = 4'd6;
    Bi = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_di = '0;
    exp_bo = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_di", 32'(Di), 32'd0);
    chk("abort_bo", 32'(Bo), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", 32'(done), 32'd0);
      tick();
    end
    run_op(4'd12, 4'd5, 1'b1);

    // start held high: one op per 6 cycles
    begin
      int last_c;
      int n;
      last_c = -1;
      n = 0;
      Ai = 4'd5;
      Bi = 4'd6;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 20; c++) begin
        if (done) begin
          chk("held_di", 32'(Di), 32'd15);
          chk("held_bo", 32'(Bo), 32'd1);
          if (last_c < 0) chk("held_first", 32'(c), 32'd5);
          else chk("held_gap", 32'(c - last_c), 32'd6);
          last_c = c;
          n++;
        end
        tick();
      end
      chk("held_count", 32'(n), 32'd3);
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      exp_di = 4'd15;
      exp_bo = 1'b1;
    end

    // exhaustive
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
